// File: rtl/req_capture_amisha_if.sv
// Request-capture bus: async request levels and code acknowledge in, frozen pending snapshot out.
// state_dbg mirrors the capture FSM (0 = IDLE, 1 = OFFER).
interface req_capture_amisha_if;
  logic [4:1] req_in_amisha;
  logic       ack_amisha;
  logic [2:0] ack_code_amisha;
  logic [4:1] r_amisha;
  logic       valid_amisha;
  logic       protocol_err_amisha;
  logic [7:0] drop_cnt_amisha;
  logic       state_dbg;

  modport master (
    output req_in_amisha, ack_amisha, ack_code_amisha,
    input  r_amisha, valid_amisha, protocol_err_amisha, drop_cnt_amisha, state_dbg
  );

  modport slave (
    input  req_in_amisha, ack_amisha, ack_code_amisha,
    output r_amisha, valid_amisha, protocol_err_amisha, drop_cnt_amisha, state_dbg
  );
endinterface

// File: rtl/req_capture_amisha.sv
// Synchronizes four request lines, keeps sticky pending bits and offers a frozen snapshot to the encoder.
// Optional macro REQ_CAPTURE_DROP_CNT_EN builds the saturating dropped-edge counter.
module req_capture_amisha #(
  parameter int SYNC_STAGES = 2
) (
  input logic clk_amisha,
  input logic reset_amisha,
  req_capture_amisha_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state;
  logic [4:1] sync_q [SYNC_STAGES];
  logic [4:1] hist_q;
  logic [4:1] pend_q;
  logic [4:1] r_q;
  logic       valid_q;
  logic       err_q;

  logic [4:1] rise;
  logic [4:1] code_mask;
  logic [4:1] clr_mask;
  logic [4:1] pend_next;
  logic       ack_ok;

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= bus.req_in_amisha;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Offer/ack handshake: valid_amisha=1 means r_amisha is a stable offer. A cycle with
  // ack_amisha=1 and a code whose bit is set in r_amisha is a transfer; r_amisha changes
  // only on a transfer or when a new offer opens from IDLE. Any other ack in OFFER is an error.
  always_comb begin
    code_mask = '0;
    case (bus.ack_code_amisha)
      3'd1:    code_mask = 4'b0001;
      3'd2:    code_mask = 4'b0010;
      3'd3:    code_mask = 4'b0100;
      3'd4:    code_mask = 4'b1000;
      default: code_mask = '0;
    endcase
    ack_ok    = (state == OFFER) && bus.ack_amisha && ((code_mask & r_q) != '0);
    clr_mask  = ack_ok ? code_mask : '0;
    rise      = sync_q[SYNC_STAGES-1] & ~hist_q;
    pend_next = (pend_q & ~clr_mask) | rise;
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) pend_q <= '0;
    else              pend_q <= pend_next;
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state   <= IDLE;
      r_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (pend_q != '0) begin
            state   <= OFFER;
            r_q     <= pend_q;
            valid_q <= 1'b1;
          end
        end
        OFFER: begin
          err_q <= bus.ack_amisha && !ack_ok;
          if (ack_ok) begin
            if (pend_next != '0) begin
              r_q <= pend_next;
            end else begin
              state   <= IDLE;
              r_q     <= '0;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          r_q     <= '0;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef REQ_CAPTURE_DROP_CNT_EN
  logic [4:1] dropped;
  logic [2:0] n_drop;
  logic [8:0] drop_sum;
  logic [7:0] drop_q;

  // Several bits may drop in one cycle; each counts once.
  always_comb begin
    dropped  = rise & pend_q & ~clr_mask;
    n_drop   = {2'b00, dropped[1]} + {2'b00, dropped[2]} + {2'b00, dropped[3]} + {2'b00, dropped[4]};
    drop_sum = {1'b0, drop_q} + {6'd0, n_drop};
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) drop_q <= '0;
    else              drop_q <= drop_sum[8] ? 8'hff : drop_sum[7:0];
  end

  assign bus.drop_cnt_amisha = drop_q;
`else
  assign bus.drop_cnt_amisha = 8'd0;
`endif

  assign bus.r_amisha            = r_q;
  assign bus.valid_amisha        = valid_q;
  assign bus.protocol_err_amisha = err_q;
  assign bus.state_dbg           = (state == OFFER);

endmodule

// File: tb/tb_req_capture_amisha.sv
// Bench for req_capture_amisha: directed scenarios plus randomized traffic against a request-set model.
// Drop expectations follow REQ_CAPTURE_DROP_CNT_EN.
module tb_req_capture_amisha;
  localparam int S = 2;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  req_capture_amisha_if bus();

  req_capture_amisha #(.SYNC_STAGES(S)) dut (
    .clk_amisha  (clk),
    .reset_amisha(rst),
    .bus         (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // lv[0] is the most recent sampled level; a request is seen S edges after it is sampled.
  logic [4:1] lv[$];
  logic [4:1] m_pend, m_offer;
  logic       m_valid, m_err;
  int         m_drop;
  logic [3:0] exp_q[$];

  function automatic logic [7:0] exp_drop(input int n);
`ifdef REQ_CAPTURE_DROP_CNT_EN
    return 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  task automatic model_reset();
    lv.delete();
    for (int i = 0; i <= S; i++) lv.push_back(4'b0000);
    m_pend = '0; m_offer = '0; m_valid = 1'b0; m_err = 1'b0; m_drop = 0;
  endtask

  task automatic model_edge();
    logic [4:1] rise, mask, nxt;
    logic       legal, err_n;
    int         c;
    rise  = lv[S-1] & ~lv[S];
    mask  = '0; legal = 1'b0; err_n = 1'b0;
    c = int'(bus.ack_code_amisha);
    if (c >= 1 && c <= 4) mask = 4'(1 << (c - 1));
    if (m_valid && bus.ack_amisha) begin
      if ((mask & m_offer) != '0) legal = 1'b1;
      else                        err_n = 1'b1;
    end
    if (!legal) mask = '0;
    nxt = (m_pend & ~mask) | rise;
    for (int i = 1; i <= 4; i++)
      if (rise[i] && m_pend[i] && !mask[i] && m_drop < 255) m_drop++;
    if (!m_valid) begin
      if (m_pend != '0) begin m_valid = 1'b1; m_offer = m_pend; end
    end else if (legal) begin
      if (nxt != '0) m_offer = nxt;
      else begin m_valid = 1'b0; m_offer = '0; end
    end
    m_pend = nxt;
    m_err  = err_n;
    lv.push_front(bus.req_in_amisha);
    void'(lv.pop_back());
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic settle();
    bus.req_in_amisha = '0; bus.ack_amisha = 1'b0; bus.ack_code_amisha = '0;
    repeat (S + 3) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_in_amisha = '0; bus.ack_amisha = 1'b0; bus.ack_code_amisha = '0;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic ack(input logic [2:0] code);
    bus.ack_amisha = 1'b1; bus.ack_code_amisha = code;
    step();
    bus.ack_amisha = 1'b0; bus.ack_code_amisha = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (bus.valid_amisha !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (bus.valid_amisha !== 1'b1) begin
      failures++; $display("FAIL %s_timeout valid=%b exp=1", tag, bus.valid_amisha);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.req_in_amisha = 4'b0100; bus.ack_amisha = 1'b0; bus.ack_code_amisha = '0;
    model_reset();
    repeat (2) step();
    checks++; if (bus.r_amisha !== 4'b0000) begin failures++; $display("FAIL rst_r got=%b exp=0000", bus.r_amisha); end
    checks++; if (bus.valid_amisha !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.valid_amisha); end
    checks++; if (bus.protocol_err_amisha !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.protocol_err_amisha); end
    checks++; if (bus.drop_cnt_amisha !== 8'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", bus.drop_cnt_amisha); end
    rst = 1'b0;
    for (int i = 1; i <= S + 1; i++) begin
      step();
      checks++;
      if (bus.valid_amisha !== 1'b0) begin failures++; $display("FAIL rst_latency_early edge=%0d valid=%b exp=0", i, bus.valid_amisha); end
    end
    step();
    checks++; if (bus.valid_amisha !== 1'b1) begin failures++; $display("FAIL rst_latency_valid got=%b exp=1", bus.valid_amisha); end
    checks++; if (bus.r_amisha !== 4'b0100) begin failures++; $display("FAIL rst_latency_r got=%b exp=0100", bus.r_amisha); end
    bus.req_in_amisha = '0;
    ack(3'd3);
    checks++; if (bus.valid_amisha !== 1'b0) begin failures++; $display("FAIL rst_ack_idle valid=%b exp=0", bus.valid_amisha); end
    settle();
  endtask

  task automatic test_priority();
    logic [3:0] e;
    settle();
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0001);
    bus.req_in_amisha = 4'b1001;
    wait_valid("prio");
    e = exp_q.pop_front();
    checks++; if (bus.r_amisha !== e) begin failures++; $display("FAIL prio_first r=%b exp=%b", bus.r_amisha, e); end
    ack(3'd4);
    e = exp_q.pop_front();
    checks++; if (bus.r_amisha !== e) begin failures++; $display("FAIL prio_second r=%b exp=%b", bus.r_amisha, e); end
    checks++; if (bus.valid_amisha !== 1'b1) begin failures++; $display("FAIL prio_b2b_valid got=%b exp=1", bus.valid_amisha); end
    ack(3'd1);
    checks++; if (bus.valid_amisha !== 1'b0) begin failures++; $display("FAIL prio_done_valid got=%b exp=0", bus.valid_amisha); end
    checks++; if (bus.r_amisha !== 4'b0000) begin failures++; $display("FAIL prio_done_r got=%b exp=0000", bus.r_amisha); end
    settle();
  endtask

  task automatic test_snapshot();
    settle();
    bus.req_in_amisha = 4'b0010;
    wait_valid("snap");
    bus.req_in_amisha = 4'b0110;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.r_amisha !== 4'b0010) begin failures++; $display("FAIL snap_hold cyc=%0d r=%b exp=0010", i, bus.r_amisha); end
    end
    ack(3'd2);
    checks++; if (bus.r_amisha !== 4'b0100) begin failures++; $display("FAIL snap_next r=%b exp=0100", bus.r_amisha); end
    checks++; if (bus.valid_amisha !== 1'b1) begin failures++; $display("FAIL snap_next_valid got=%b exp=1", bus.valid_amisha); end
    ack(3'd3);
    checks++; if (bus.valid_amisha !== 1'b0) begin failures++; $display("FAIL snap_done_valid got=%b exp=0", bus.valid_amisha); end
    settle();
  endtask

  task automatic test_illegal();
    settle();
    bus.req_in_amisha = 4'b0010;
    wait_valid("ill");
    bus.ack_amisha = 1'b1; bus.ack_code_amisha = 3'd4;
    step();
    checks++; if (bus.protocol_err_amisha !== 1'b1) begin failures++; $display("FAIL ill_code4_err got=%b exp=1", bus.protocol_err_amisha); end
    checks++; if (bus.r_amisha !== 4'b0010) begin failures++; $display("FAIL ill_code4_r got=%b exp=0010", bus.r_amisha); end
    bus.ack_code_amisha = 3'd7;
    step();
    checks++; if (bus.protocol_err_amisha !== 1'b1) begin failures++; $display("FAIL ill_code7_err got=%b exp=1", bus.protocol_err_amisha); end
    checks++; if (bus.valid_amisha !== 1'b1) begin failures++; $display("FAIL ill_code7_valid got=%b exp=1", bus.valid_amisha); end
    bus.ack_amisha = 1'b0; bus.ack_code_amisha = '0;
    step();
    checks++; if (bus.protocol_err_amisha !== 1'b0) begin failures++; $display("FAIL ill_err_pulse got=%b exp=0", bus.protocol_err_amisha); end
    checks++; if (bus.r_amisha !== 4'b0010) begin failures++; $display("FAIL ill_r_kept got=%b exp=0010", bus.r_amisha); end
    ack(3'd2);
    checks++; if (bus.valid_amisha !== 1'b0) begin failures++; $display("FAIL ill_clear_valid got=%b exp=0", bus.valid_amisha); end
    ack(3'd7);
    checks++; if (bus.protocol_err_amisha !== 1'b0) begin failures++; $display("FAIL ill_idle_err got=%b exp=0", bus.protocol_err_amisha); end
    settle();
  endtask

  task automatic test_drops_setwins();
    do_reset();
    bus.req_in_amisha = 4'b0010;
    wait_valid("drop");
    repeat (3) begin
      bus.req_in_amisha = 4'b0000; repeat (2) step();
      bus.req_in_amisha = 4'b0010; repeat (2) step();
    end
    repeat (S + 2) step();
    checks++; if (bus.drop_cnt_amisha !== exp_drop(3)) begin failures++; $display("FAIL drop_count got=%0d exp=%0d", bus.drop_cnt_amisha, exp_drop(3)); end
    bus.req_in_amisha = 4'b0000; repeat (S + 2) step();
    bus.req_in_amisha = 4'b0010; repeat (S) step();
    ack(3'd2);
    checks++; if (bus.valid_amisha !== 1'b1) begin failures++; $display("FAIL setwin_valid got=%b exp=1", bus.valid_amisha); end
    checks++; if (bus.r_amisha !== 4'b0010) begin failures++; $display("FAIL setwin_r got=%b exp=0010", bus.r_amisha); end
    checks++; if (bus.drop_cnt_amisha !== exp_drop(3)) begin failures++; $display("FAIL setwin_nodrop got=%0d exp=%0d", bus.drop_cnt_amisha, exp_drop(3)); end
    ack(3'd2);
    checks++; if (bus.valid_amisha !== 1'b0) begin failures++; $display("FAIL setwin_clear got=%b exp=0", bus.valid_amisha); end
    settle();
  endtask

  task automatic test_random();
    logic [2:0] code;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) bus.req_in_amisha = 4'($urandom_range(0, 15));
      bus.ack_amisha = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) code = 3'($urandom_range(0, 7));
      else begin
        code = 3'd0;
        for (int i = 1; i <= 4; i++) if (m_offer[i]) code = 3'(i);
      end
      bus.ack_code_amisha = code;
      step();
      checks++;
      if (bus.r_amisha !== m_offer || bus.valid_amisha !== m_valid || bus.protocol_err_amisha !== m_err ||
          bus.drop_cnt_amisha !== exp_drop(m_drop) || bus.state_dbg !== m_valid) begin
        failures++;
        $display("FAIL rand cyc=%0d r=%b/%b valid=%b/%b err=%b/%b drop=%0d/%0d state=%b (got/exp)", n,
                 bus.r_amisha, m_offer, bus.valid_amisha, m_valid, bus.protocol_err_amisha, m_err,
                 bus.drop_cnt_amisha, exp_drop(m_drop), bus.state_dbg);
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_in_amisha = 4'b1100;
    wait_valid("mid");
    checks++; if (bus.r_amisha !== 4'b1100) begin failures++; $display("FAIL mid_offer r=%b exp=1100", bus.r_amisha); end
    bus.req_in_amisha = 4'b0100; repeat (2) step();
    bus.req_in_amisha = 4'b1100; repeat (S + 2) step();
    checks++; if (bus.drop_cnt_amisha !== exp_drop(1)) begin failures++; $display("FAIL mid_drop got=%0d exp=%0d", bus.drop_cnt_amisha, exp_drop(1)); end
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.valid_amisha !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", bus.valid_amisha); end
    checks++; if (bus.r_amisha !== 4'b0000) begin failures++; $display("FAIL mid_async_r got=%b exp=0000", bus.r_amisha); end
    checks++; if (bus.drop_cnt_amisha !== 8'd0) begin failures++; $display("FAIL mid_async_drop got=%0d exp=0", bus.drop_cnt_amisha); end
    bus.req_in_amisha = '0;
    step();
    rst = 1'b0;
    settle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    bus.req_in_amisha = '0; bus.ack_amisha = 1'b0; bus.ack_code_amisha = '0;
    model_reset();
    test_reset();
    test_priority();
    test_snapshot();
    test_illegal();
    test_drops_setwins();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_capture_amisha.md
# req_capture_amisha

Request-capture stage that sits directly upstream of the 4-input priority encoder. It synchronizes four asynchronous request lines, detects their rising edges and holds each request as a sticky pending bit. It presents a frozen snapshot of the pending set on `r_amisha[4:1]` for the encoder. The consumer returns the encoder's 3-bit code with an acknowledge, and the block clears exactly that request.

## Interface
- `SYNC_STAGES`, default 2: depth of the input synchronizer chain per request line. Legal values are 2 to 4.
- `clk_amisha` in, 1 bit: single clock; all state is updated on its rising edge.
- `reset_amisha` in, 1 bit: asynchronous, active-high reset.
- `req_in_amisha` in, [4:1]: asynchronous request levels. Bit 4 has the highest priority.
- `ack_amisha` in, 1 bit: the consumer has serviced the request named by `ack_code_amisha`.
- `ack_code_amisha` in, [2:0]: encoder code being acknowledged. 3'b001 to 3'b100 map to bits 1 to 4.
- `r_amisha` out, [4:1]: registered snapshot of pending requests; feeds the encoder input.
- `valid_amisha` out, 1 bit: `r_amisha` holds a non-zero offer.
- `protocol_err_amisha` out, 1 bit: one-cycle pulse on an illegal acknowledge.
- `drop_cnt_amisha` out, [7:0]: saturating count of dropped request edges (see Configuration).

## Operation
- **Synchronizer.** Each `req_in_amisha` bit passes through `SYNC_STAGES` flops, then one history flop. A rising edge is `sync & ~hist`.
- **Pending register** `pend[4:1]`. A detected edge sets its bit. An accepted acknowledge clears the acknowledged bit.
  - If an edge and a clear hit the same bit in the same cycle, the bit ends up **set**. The new edge is a fresh request.
- **Dropped edge.** An edge on a bit that is already pending and not being cleared that cycle is dropped. It increments `drop_cnt_amisha`, which saturates at 255.
- **FSM, two states:**
  - **IDLE**: `valid_amisha`=0 and `r_amisha`=0. When `pend` ≠ 0, move to OFFER and load `r_amisha` ← `pend`.
  - **OFFER**: `valid_amisha`=1 and `r_amisha` is held stable. New edges accumulate in `pend` only.
    - On `ack_amisha` with a legal code (1 to 4), clear `pend[code]`. Let `pend_next` be `pend` after this clear plus same-cycle edges.
    - If `pend_next` ≠ 0: stay in OFFER and reload `r_amisha` ← `pend_next` on the same edge.
    - Otherwise: go to IDLE.
- **Illegal acknowledge.** In OFFER, a code of 000 or 101 to 111, or a code whose bit is 0 in `r_amisha`, is illegal.
  - Nothing is cleared and the state and snapshot are unchanged.
  - `protocol_err_amisha`=1 for the next cycle.
- **Acknowledge in IDLE.** Ignored; no error is flagged.
- **Reset values.** Sync chain, history, `pend`, `r_amisha`, `valid_amisha`, `protocol_err_amisha` and `drop_cnt_amisha` are all 0, and the state is IDLE.
  - A request held high through reset is therefore captured as a new edge after reset deasserts.
  - Asserting reset mid-offer discards all pending requests immediately, without waiting for a clock edge.

## Timing
- Let `req_in_amisha[i]` be first sampled high at clock edge k.
  - `pend[i]` sets at edge k+`SYNC_STAGES`.
  - In IDLE, `valid_amisha` and `r_amisha` update at edge k+`SYNC_STAGES`+1.
  - Default latency is 3 edges.
- Acknowledge to next offer:
  - With requests remaining, the next offer appears on the edge that samples `ack_amisha`, so back-to-back service has no idle cycle.
  - With nothing left, `valid_amisha` drops on that same edge.
- `r_amisha` changes only on an acknowledged edge or an IDLE→OFFER edge. The encoder output is therefore stable for the whole offer.
- `protocol_err_amisha` lasts exactly one cycle per illegal acknowledge cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `REQ_CAPTURE_DROP_CNT_EN`.
- **Defined:** the 8-bit saturating drop counter is built as described above.
- **Not defined:** no counter logic is synthesized and `drop_cnt_amisha` is tied to 8'd0. The dropped edge itself is still discarded.
- All other behaviour is identical in both builds.

## Test plan
- **Reset with a held request.** Hold reset with `req_in_amisha`=4'b0100, then release. Required: `valid_amisha`=1 and `r_amisha`=4'b0100 exactly 3 edges later; all outputs were 0 during reset.
- **Simultaneous requests, priority service.** Raise bits 4 and 1 on the same cycle. Required: `r_amisha`=4'b1001. Acknowledge code 100; then `r_amisha`=4'b0001 on the same edge and valid stays high. Acknowledge code 001; then valid=0 and `r_amisha`=0.
- **Snapshot stability.** While offering 4'b0010, raise bit 3. Required: `r_amisha` stays 4'b0010 until the acknowledge of 010; the next offer is 4'b0100.
- **Illegal acknowledge.** While offering 4'b0010, acknowledge with code 100, then with code 111. Required: `protocol_err_amisha` pulses once per acknowledge cycle, and the offer stays 4'b0010 with valid=1.
- **Drops and set-wins.**
  - With bit 2 pending, pulse bit 2 three times (low-high each). Required: `drop_cnt_amisha`=3, or 0 when the macro is undefined.
  - Land an edge on bit 2 in the same cycle as its acknowledge. Required: `pend[2]` stays set and the next offer contains bit 2.
- **Reset mid-operation.** While offering 4'b1100, assert reset asynchronously between clock edges. Required: `valid_amisha`, `r_amisha` and `drop_cnt_amisha` go to 0 immediately, without waiting for a clock edge.
